// File: rtl/scan_mux_pkg.sv
// Shared definitions for the scan multiplexer: mode encodings.
package scan_mux_pkg;

  typedef enum logic {
    MODE_MAN  = 1'b0,
    MODE_SCAN = 1'b1
  } mode_e;

endpackage

// File: rtl/mux_nx1.sv
// Combinational N-to-1 channel selector; indices at or beyond NCH yield zero.
module mux_nx1 #(
  parameter int WIDTH = 1,
  parameter int NCH   = 4,
  parameter int SELW  = 2
) (
  input  logic [NCH*WIDTH-1:0] din,
  input  logic [SELW-1:0]      idx,
  output logic [WIDTH-1:0]     y
);

  always_comb begin
    // NOTE: default first so every path assigns y; otherwise a latch is inferred.
    y = '0;
    for (int i = 0; i < NCH; i++) begin
      if (idx == SELW'(i)) y = din[i*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/scan_mux.sv
// Registered channel multiplexer with manual select and round-robin scan modes.
module scan_mux
  import scan_mux_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int NCH   = 4,
  parameter int SELW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH*WIDTH-1:0] din,
  input  logic [SELW-1:0]      sel,
  input  logic                 mode,
  input  logic                 en,
  output logic [WIDTH-1:0]     dout,
  output logic [SELW-1:0]      dout_ch,
  output logic                 dout_valid,
  output logic                 wrap
);

  localparam logic [SELW-1:0] LAST_CH = SELW'(NCH - 1);
  localparam logic [SELW:0]   NCH_W   = (SELW + 1)'(NCH);

  mode_e           cur_mode;
  logic [SELW-1:0] ptr;
  logic [SELW-1:0] ptr_next;
  logic [SELW-1:0] idx;
  logic [WIDTH-1:0] mux_y;
  logic            ptr_last;
  logic            sel_ok;

  assign cur_mode = mode_e'(mode);
  assign ptr_last = (ptr == LAST_CH);
  assign sel_ok   = ({1'b0, sel} < NCH_W);
  assign idx      = (cur_mode == MODE_SCAN) ? ptr : sel;

  mux_nx1 #(
    .WIDTH (WIDTH),
    .NCH   (NCH),
    .SELW  (SELW)
  ) u_mux (
    .din (din),
    .idx (idx),
    .y   (mux_y)
  );

  // Manual mode parks the pointer at 0 so each scan entry begins a full sweep.
  always_comb begin
    ptr_next = ptr;
    if (cur_mode == MODE_MAN) begin
      ptr_next = '0;
    end else if (en) begin
      ptr_next = ptr_last ? '0 : ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep all registers updating from pre-edge values.
    if (rst) begin
      ptr        <= '0;
      dout       <= '0;
      dout_ch    <= '0;
      dout_valid <= 1'b0;
      wrap       <= 1'b0;
    end else begin
      ptr <= ptr_next;
      if (en) begin
        dout       <= mux_y;
        dout_ch    <= idx;
        dout_valid <= (cur_mode == MODE_SCAN) ? 1'b1 : sel_ok;
        wrap       <= (cur_mode == MODE_SCAN) && ptr_last;
      end else begin
        dout_valid <= 1'b0;
        wrap       <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_scan_mux.sv
// Scoreboard bench for scan_mux: a 4-channel and a 3-channel instance driven in lockstep.
module tb_scan_mux;

  typedef struct {
    logic [3:0] dout;
    logic [1:0] ch;
    logic       v;
    logic       w;
    int         ptr;
  } model_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode;
  logic        en;
  logic [1:0]  sel;
  logic [15:0] din4;
  logic [11:0] din3;

  logic [3:0] dout4, dout3;
  logic [1:0] ch4, ch3;
  logic       v4, v3, w4, w3;

  int total = 0;
  int bad   = 0;

  model_t m4, m3;
  model_t q4[$];
  model_t q3[$];

  always #5 clk = ~clk;

  scan_mux #(.WIDTH(4), .NCH(4), .SELW(2)) dut4 (
    .clk(clk), .rst(rst), .din(din4), .sel(sel), .mode(mode), .en(en),
    .dout(dout4), .dout_ch(ch4), .dout_valid(v4), .wrap(w4)
  );

  scan_mux #(.WIDTH(4), .NCH(3), .SELW(2)) dut3 (
    .clk(clk), .rst(rst), .din(din3), .sel(sel), .mode(mode), .en(en),
    .dout(dout3), .dout_ch(ch3), .dout_valid(v3), .wrap(w3)
  );

  function automatic model_t model_next(model_t s, int nch, logic [15:0] d,
                                        logic r, logic m, logic [1:0] sl, logic e);
    model_t n = s;
    if (r) begin
      n.dout = '0; n.ch = '0; n.v = 1'b0; n.w = 1'b0; n.ptr = 0;
      return n;
    end
    n.v = 1'b0;
    n.w = 1'b0;
    if (e) begin
      if (m) begin
        n.dout = 4'((d >> (4 * s.ptr)) & 16'hF);
        n.ch   = 2'(s.ptr);
        n.v    = 1'b1;
        n.w    = (s.ptr == nch - 1);
        n.ptr  = (s.ptr + 1) % nch;
      end else begin
        n.dout = (int'(sl) < nch) ? 4'((d >> (4 * int'(sl))) & 16'hF) : 4'h0;
        n.ch   = sl;
        n.v    = (int'(sl) < nch);
      end
    end
    if (!m) n.ptr = 0;
    return n;
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, push expectations, then pop and compare after the edge.
  task automatic cyc(input logic r, input logic m, input logic [1:0] sl, input logic e);
    model_t e4, e3;
    @(negedge clk);
    rst = r; mode = m; sel = sl; en = e;
    m4 = model_next(m4, 4, din4, r, m, sl, e);
    m3 = model_next(m3, 3, {4'h0, din3}, r, m, sl, e);
    q4.push_back(m4);
    q3.push_back(m3);
    @(posedge clk);
    #1;
    e4 = q4.pop_front();
    e3 = q3.pop_front();
    check("dout4",  dout4,        e4.dout);
    check("ch4",    {2'b0, ch4},  {2'b0, e4.ch});
    check("valid4", {3'b0, v4},   {3'b0, e4.v});
    check("wrap4",  {3'b0, w4},   {3'b0, e4.w});
    check("dout3",  dout3,        e3.dout);
    check("ch3",    {2'b0, ch3},  {2'b0, e3.ch});
    check("valid3", {3'b0, v3},   {3'b0, e3.v});
    check("wrap3",  {3'b0, w3},   {3'b0, e3.w});
  endtask

  logic [3:0] scan_seq [9];
  logic [1:0] ch3_seq  [7];

  initial begin
    scan_seq = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hA, 4'hB, 4'hC, 4'hD, 4'hA};
    ch3_seq  = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0};
    m4 = '{dout: 4'h0, ch: 2'd0, v: 1'b0, w: 1'b0, ptr: 0};
    m3 = m4;
    din4 = 16'hDCBA;
    din3 = 12'hCBA;
    rst = 1'b1; mode = 1'b1; en = 1'b1; sel = 2'd0;

    // Reset held two cycles with scan enabled.
    repeat (2) begin
      cyc(1'b1, 1'b1, 2'd0, 1'b1);
      check("rst_dout", dout4, 4'h0);
      check("rst_valid", {3'b0, v4}, 4'h0);
    end

    // Manual select of channel 2.
    cyc(1'b0, 1'b0, 2'd2, 1'b1);
    check("man_dout", dout4, 4'hC);
    check("man_ch", {2'b0, ch4}, 4'd2);

    // Nine scan cycles; wrap only on D for the 4-channel instance.
    for (int i = 0; i < 9; i++) begin
      cyc(1'b0, 1'b1, 2'd3, 1'b1);
      check("scan_seq", dout4, scan_seq[i]);
      check("scan_wrap", {3'b0, w4}, (scan_seq[i] == 4'hD) ? 4'd1 : 4'd0);
      if (i < 7) check("scan3_ch", {2'b0, ch3}, {2'b0, ch3_seq[i]});
    end

    // Out-of-range select on the 3-channel instance.
    cyc(1'b0, 1'b0, 2'd3, 1'b1);
    check("sel3_valid", {3'b0, v3}, 4'd0);
    check("sel3_dout", dout3, 4'h0);

    // Hold/resume: scan ch0, ch1, drop en for 3 cycles, resume at ch2.
    cyc(1'b0, 1'b1, 2'd0, 1'b1);
    cyc(1'b0, 1'b1, 2'd0, 1'b1);
    repeat (3) begin
      cyc(1'b0, 1'b1, 2'd0, 1'b0);
      check("hold_dout", dout4, 4'hB);
    end
    cyc(1'b0, 1'b1, 2'd0, 1'b1);
    check("resume_ch", {2'b0, ch4}, 4'd2);

    // Mid-sweep reset restarts at ch0 without a wrap pulse.
    cyc(1'b0, 1'b0, 2'd0, 1'b1);
    cyc(1'b0, 1'b1, 2'd0, 1'b1);
    cyc(1'b0, 1'b1, 2'd0, 1'b1);
    cyc(1'b1, 1'b1, 2'd0, 1'b1);
    cyc(1'b0, 1'b1, 2'd0, 1'b1);
    check("rst_restart", {2'b0, ch4}, 4'd0);

    // Mid-sweep switch to manual outputs sel immediately, then rescans from ch0.
    cyc(1'b0, 1'b1, 2'd0, 1'b1);
    cyc(1'b0, 1'b0, 2'd3, 1'b1);
    check("switch_man", dout4, 4'hD);
    check("switch_wrap", {3'b0, w4}, 4'd0);
    cyc(1'b0, 1'b1, 2'd1, 1'b1);
    check("man_restart", {2'b0, ch4}, 4'd0);

    // Changing data every cycle in both modes.
    for (int i = 0; i < 12; i++) begin
      din4 = 16'($urandom);
      din3 = 12'($urandom);
      cyc(1'b0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
